// File: rtl/ddr3_cmd_monitor.sv
// rtl/ddr3_cmd_monitor.sv - DDR3 command bus decoder with bank-state tracking and timing/protocol checks
module ddr3_cmd_monitor #(
  parameter int unsigned TRCD = 6,
  parameter int unsigned TRP  = 6,
  parameter int unsigned TRFC = 44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] ddr_addr,
  input  logic [2:0]  ddr_bank,
  input  logic        ddr_cs,
  input  logic        ddr_ras,
  input  logic        ddr_cas,
  input  logic        ddr_we,
  input  logic        ddr_cke,
  input  logic        ddr_reset_n,
  input  logic        err_clear,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [2:0]  cmd_bank,
  output logic [13:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        cmd_ap,
  output logic [7:0]  bank_open,
  output logic [13:0] mr0,
  output logic [13:0] mr1,
  output logic [13:0] mr2,
  output logic [13:0] mr3,
  output logic [6:0]  err_flags,
  output logic [15:0] err_cnt
);

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ACT  = 4'd1;
  localparam logic [3:0] CMD_RD   = 4'd2;
  localparam logic [3:0] CMD_WR   = 4'd3;
  localparam logic [3:0] CMD_PRE  = 4'd4;
  localparam logic [3:0] CMD_PREA = 4'd5;
  localparam logic [3:0] CMD_REF  = 4'd6;
  localparam logic [3:0] CMD_MRS  = 4'd7;
  localparam logic [3:0] CMD_ZQ   = 4'd8;

  localparam logic [7:0] TRCD_C    = 8'(TRCD);
  localparam logic [7:0] TRP_C     = 8'(TRP);
  localparam logic [7:0] TRFC_C    = 8'(TRFC);
  localparam logic [7:0] CNT_SAT   = 8'hFF;
  // Restarting at 1 makes the counter equal the edge distance k when the next command is sampled.
  localparam logic [7:0] CNT_START = 8'd1;

  logic [3:0]       code;
  logic             is_rdwr;

  logic             cmd_valid_q, cmd_valid_d;
  logic [3:0]       cmd_code_q, cmd_code_d;
  logic [2:0]       cmd_bank_q, cmd_bank_d;
  logic [13:0]      cmd_row_q, cmd_row_d;
  logic [9:0]       cmd_col_q, cmd_col_d;
  logic             cmd_ap_q, cmd_ap_d;
  logic [7:0]       bank_open_q, bank_open_d;
  logic [7:0][7:0]  bank_cnt_q, bank_cnt_d;
  logic [7:0]       ref_cnt_q, ref_cnt_d;
  logic [3:0][13:0] mr_q, mr_d;
  logic [6:0]       err_flags_q, err_flags_d;
  logic [6:0]       new_err;
  logic [15:0]      err_cnt_q, err_cnt_d;

  always_comb begin
    code = CMD_NONE;
    if (ddr_cke && ddr_reset_n && !ddr_cs) begin
      case ({ddr_ras, ddr_cas, ddr_we})
        3'b011:  code = CMD_ACT;
        3'b101:  code = CMD_RD;
        3'b100:  code = CMD_WR;
        3'b010:  code = ddr_addr[10] ? CMD_PREA : CMD_PRE;
        3'b001:  code = CMD_REF;
        3'b000:  code = CMD_MRS;
        3'b110:  code = CMD_ZQ;
        default: code = CMD_NONE;
      endcase
    end
  end

  assign is_rdwr = (code == CMD_RD) || (code == CMD_WR);

  always_comb begin
    cmd_valid_d = (code != CMD_NONE);
    cmd_code_d  = code;
    cmd_bank_d  = cmd_valid_d ? ddr_bank : 3'd0;
    cmd_row_d   = (code == CMD_ACT) ? ddr_addr : 14'd0;
    cmd_col_d   = is_rdwr ? ddr_addr[9:0] : 10'd0;
    cmd_ap_d    = is_rdwr ? ddr_addr[10] : 1'b0;

    bank_open_d = bank_open_q;
    mr_d        = mr_q;
    new_err     = '0;
    ref_cnt_d   = (ref_cnt_q == CNT_SAT) ? CNT_SAT : ref_cnt_q + 8'd1;
    for (int b = 0; b < 8; b++) begin
      bank_cnt_d[b] = (bank_cnt_q[b] == CNT_SAT) ? CNT_SAT : bank_cnt_q[b] + 8'd1;
    end

    if (cmd_valid_d && (ref_cnt_q < TRFC_C)) new_err[4] = 1'b1;

    // An open bank's counter runs from its ACT; a closed bank's counter runs from its last close.
    case (code)
      CMD_ACT: begin
        if (bank_open_q[ddr_bank])               new_err[0] = 1'b1;
        else if (bank_cnt_q[ddr_bank] < TRP_C)   new_err[3] = 1'b1;
        bank_open_d[ddr_bank] = 1'b1;
        bank_cnt_d[ddr_bank]  = CNT_START;
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open_q[ddr_bank])              new_err[1] = 1'b1;
        else if (bank_cnt_q[ddr_bank] < TRCD_C)  new_err[2] = 1'b1;
        if (ddr_addr[10]) begin
          bank_open_d[ddr_bank] = 1'b0;
          bank_cnt_d[ddr_bank]  = CNT_START;
        end
      end
      CMD_PRE: begin
        bank_open_d[ddr_bank] = 1'b0;
        bank_cnt_d[ddr_bank]  = CNT_START;
      end
      CMD_PREA: begin
        bank_open_d = '0;
        bank_cnt_d  = {8{CNT_START}};
      end
      CMD_REF: begin
        if (|bank_open_q) new_err[5] = 1'b1;
        ref_cnt_d = CNT_START;
      end
      CMD_MRS: begin
        if (|bank_open_q) new_err[6] = 1'b1;
        mr_d[ddr_bank[1:0]] = ddr_addr;
      end
      default: ;
    endcase

    if (!ddr_reset_n) begin
      bank_open_d = '0;
      bank_cnt_d  = {8{CNT_SAT}};
      ref_cnt_d   = CNT_SAT;
    end

    err_flags_d = (err_clear ? 7'd0 : err_flags_q) | new_err;
    if (err_clear)                                  err_cnt_d = {15'd0, |new_err};
    else if ((|new_err) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    else                                            err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_ap_q    <= 1'b0;
      bank_open_q <= '0;
      bank_cnt_q  <= {8{CNT_SAT}};
      ref_cnt_q   <= CNT_SAT;
      mr_q        <= '0;
      err_flags_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_ap_q    <= cmd_ap_d;
      bank_open_q <= bank_open_d;
      bank_cnt_q  <= bank_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      mr_q        <= mr_d;
      err_flags_q <= err_flags_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_ap    = cmd_ap_q;
  assign bank_open = bank_open_q;
  assign mr0       = mr_q[0];
  assign mr1       = mr_q[1];
  assign mr2       = mr_q[2];
  assign mr3       = mr_q[3];
  assign err_flags = err_flags_q;
  assign err_cnt   = err_cnt_q;

endmodule
